// File: rtl/m2_stage.sv
// Second memory pipeline stage: waits for the DCache load response, extracts/merges
// load data, and feeds the final GPR result to write-back and the forwarding network.
module m2_stage #(
    parameter int M1_TO_MS_BUS_WD = 149,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       m1s_to_ms_valid,
    input  logic [M1_TO_MS_BUS_WD-1:0] m1s_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_data_ok,
    input  logic [31:0]                data_rdata,
    output logic [4:0]                 ms_dest,
    output logic [31:0]                ms_result,
    output logic                       ms_load_wait
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_WAIT     = 2'd1,
        ST_BUFFERED = 2'd2,
        ST_READY    = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic                       ms_valid_q, ms_valid_d;
    logic [M1_TO_MS_BUS_WD-1:0] bus_q, bus_d;
    logic [31:0]                rdata_buf_q, rdata_buf_d;

    logic        inst_mfc0;
    logic [31:0] cp0_data;
    logic        ex;
    logic [31:0] rt_value;
    logic [11:0] mem_inst;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign inst_mfc0    = bus_q[148];
    assign cp0_data     = bus_q[147:116];
    assign ex           = bus_q[115];
    assign rt_value     = bus_q[114:83];
    assign mem_inst     = bus_q[82:71];
    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    logic        is_load;
    logic        in_is_load;
    logic        ms_ready_go;
    logic        gr_we_final;
    logic [1:0]  addr;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    // Excepted loads never issued a DCache read, so they must not wait for one.
    assign is_load    = res_from_mem & ~ex;
    assign in_is_load = m1s_to_ms_bus[70] & ~m1s_to_ms_bus[115];

    assign ms_ready_go = (state_q == ST_READY) | (state_q == ST_BUFFERED)
                       | ((state_q == ST_WAIT) & data_data_ok);
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Stray data_data_ok outside WAIT falls through every branch and is dropped.
    always_comb begin
        state_d     = state_q;
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        rdata_buf_d = rdata_buf_q;
        if (ms_allowin) begin
            if (m1s_to_ms_valid) begin
                ms_valid_d = 1'b1;
                bus_d      = m1s_to_ms_bus;
                state_d    = in_is_load ? ST_WAIT : ST_READY;
            end else begin
                ms_valid_d = 1'b0;
                state_d    = ST_EMPTY;
            end
        end else if ((state_q == ST_WAIT) && data_data_ok) begin
            rdata_buf_d = data_rdata;
            state_d     = ST_BUFFERED;
        end
    end

    assign addr      = alu_result[1:0];
    assign load_data = (state_q == ST_BUFFERED) ? rdata_buf_q : data_rdata;

    always_comb begin
        load_byte = load_data[7:0];
        case (addr)
            2'd0:    load_byte = load_data[7:0];
            2'd1:    load_byte = load_data[15:8];
            2'd2:    load_byte = load_data[23:16];
            default: load_byte = load_data[31:24];
        endcase
    end

    assign load_half = addr[1] ? load_data[31:16] : load_data[15:0];

    // lwl/lwr merge the loaded bytes into the old rt value, little-endian.
    always_comb begin
        load_result = load_data;
        case (mem_inst)
            12'h001: load_result = {{24{load_byte[7]}}, load_byte};
            12'h002: load_result = {24'd0, load_byte};
            12'h004: load_result = {{16{load_half[15]}}, load_half};
            12'h008: load_result = {16'd0, load_half};
            12'h020: begin
                case (addr)
                    2'd0:    load_result = {load_data[7:0],  rt_value[23:0]};
                    2'd1:    load_result = {load_data[15:0], rt_value[15:0]};
                    2'd2:    load_result = {load_data[23:0], rt_value[7:0]};
                    default: load_result = load_data;
                endcase
            end
            12'h040: begin
                case (addr)
                    2'd0:    load_result = load_data;
                    2'd1:    load_result = {rt_value[31:24], load_data[31:8]};
                    2'd2:    load_result = {rt_value[31:16], load_data[31:16]};
                    default: load_result = {rt_value[31:8],  load_data[31:24]};
                endcase
            end
            default: load_result = load_data;
        endcase
    end

    always_comb begin
        final_result = alu_result;
        if (inst_mfc0) begin
            final_result = cp0_data;
        end else if (is_load) begin
            final_result = load_result;
        end
    end

    assign gr_we_final  = gr_we & ~ex & ms_valid_q;
    assign ms_to_ws_bus = {gr_we_final, dest, final_result, pc};

    assign ms_dest      = (ms_valid_q & gr_we_final) ? dest : 5'd0;
    assign ms_result    = final_result;
    assign ms_load_wait = ms_valid_q & (state_q == ST_WAIT) & ~data_data_ok;

endmodule

// File: tb/tb_m2_stage.sv
// Self-checking bench for m2_stage: table-driven load/ALU vectors plus hand-written
// stall, buffering, reset and back-to-back sequences, with an output scoreboard.
module tb_m2_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         m1s_to_ms_valid;
    logic [148:0] m1s_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic         data_data_ok;
    logic [31:0]  data_rdata;
    logic [4:0]   ms_dest;
    logic [31:0]  ms_result;
    logic         ms_load_wait;

    m2_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .m1s_to_ms_valid (m1s_to_ms_valid),
        .m1s_to_ms_bus   (m1s_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .ms_dest         (ms_dest),
        .ms_result       (ms_result),
        .ms_load_wait    (ms_load_wait)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [69:0] sb[$];
    logic [69:0] sb_exp;

    typedef struct {
        string       name;
        logic [11:0] mem_inst;
        logic        res_from_mem;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [148:0] make_bus(input logic mfc0, input logic [31:0] cp0,
                                              input logic ex, input logic [31:0] rt,
                                              input logic [11:0] mi, input logic rfm,
                                              input logic we, input logic [4:0] dest,
                                              input logic [31:0] alu, input logic [31:0] pc);
        return {mfc0, cp0, ex, rt, mi, rfm, we, dest, alu, pc};
    endfunction

    task automatic checkOutput(input string name, input logic [69:0] actual,
                               input logic [69:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one instruction until the stage accepts it; returns #1 after the capturing edge.
    task automatic applyStimulus(input logic [148:0] bus, input logic [69:0] expected);
        bit ok;
        ok = 1'b0;
        m1s_to_ms_bus   = bus;
        m1s_to_ms_valid = 1'b1;
        sb.push_back(expected);
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (ms_allowin) ok = 1'b1;
            @(posedge clk);
        end
        #1;
        m1s_to_ms_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture_timeout: got no ms_allowin expected ms_allowin=1");
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got %h expected no output", ms_to_ws_bus);
            end else begin
                sb_exp = sb.pop_front();
                checkOutput("sb_out", ms_to_ws_bus, sb_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_allowin"},  70'(ms_allowin), 70'd1);
        checkOutput({tag, "_valid"},    70'(ms_to_ws_valid), 70'd0);
        checkOutput({tag, "_bus"},      ms_to_ws_bus, 70'd0);
        checkOutput({tag, "_dest"},     70'(ms_dest), 70'd0);
        checkOutput({tag, "_result"},   70'(ms_result), 70'd0);
        checkOutput({tag, "_loadwait"}, 70'(ms_load_wait), 70'd0);
    endtask

    initial begin
        int          cnt;
        logic [31:0] pc;

        reset           = 1'b1;
        ws_allowin      = 1'b1;
        m1s_to_ms_valid = 1'b0;
        m1s_to_ms_bus   = '0;
        data_data_ok    = 1'b0;
        data_rdata      = '0;

        vecs.push_back('{"lw",    12'h010, 1'b1, 32'h80001000, 32'h0,        32'h12345678, 32'h12345678});
        vecs.push_back('{"lb3",   12'h001, 1'b1, 32'h80001003, 32'h0,        32'h80FF7F00, 32'hFFFFFF80});
        vecs.push_back('{"lbu3",  12'h002, 1'b1, 32'h80001003, 32'h0,        32'h80FF7F00, 32'h00000080});
        vecs.push_back('{"lh2",   12'h004, 1'b1, 32'h80001002, 32'h0,        32'h80FF7F00, 32'hFFFF80FF});
        vecs.push_back('{"lhu2",  12'h008, 1'b1, 32'h80001002, 32'h0,        32'h80FF7F00, 32'h000080FF});
        vecs.push_back('{"lb1",   12'h001, 1'b1, 32'h80001001, 32'h0,        32'h80FF7F00, 32'h0000007F});
        vecs.push_back('{"lbu2",  12'h002, 1'b1, 32'h80001002, 32'h0,        32'h80FF7F00, 32'h000000FF});
        vecs.push_back('{"lh0",   12'h004, 1'b1, 32'h80001000, 32'h0,        32'h80FF7F00, 32'h00007F00});
        vecs.push_back('{"lwl1",  12'h020, 1'b1, 32'h80001001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344});
        vecs.push_back('{"lwl0",  12'h020, 1'b1, 32'h80001000, 32'h11223344, 32'hAABBCCDD, 32'hDD223344});
        vecs.push_back('{"lwl2",  12'h020, 1'b1, 32'h80001002, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44});
        vecs.push_back('{"lwl3",  12'h020, 1'b1, 32'h80001003, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD});
        vecs.push_back('{"lwr2",  12'h040, 1'b1, 32'h80001002, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB});
        vecs.push_back('{"lwr0",  12'h040, 1'b1, 32'h80001000, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD});
        vecs.push_back('{"lwr1",  12'h040, 1'b1, 32'h80001001, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC});
        vecs.push_back('{"lwr3",  12'h040, 1'b1, 32'h80001003, 32'h11223344, 32'hAABBCCDD, 32'h112233AA});
        vecs.push_back('{"alu",   12'h000, 1'b0, 32'h00C0FFEE, 32'h0,        32'hFFFFFFFF, 32'h00C0FFEE});
        vecs.push_back('{"sw",    12'h200, 1'b0, 32'h80002004, 32'h0,        32'hFFFFFFFF, 32'h80002004});

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkIdle("reset");
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            pc = 32'hBFC00000 + 32'(i * 4);
            applyStimulus(make_bus(1'b0, 32'h0, 1'b0, vecs[i].rt, vecs[i].mem_inst,
                                   vecs[i].res_from_mem, 1'b1, 5'd8, vecs[i].alu, pc),
                          {1'b1, 5'd8, vecs[i].result, pc});
            if (vecs[i].res_from_mem) begin
                data_data_ok = 1'b1;
                data_rdata   = vecs[i].rdata;
            end
            @(negedge clk);
            checkOutput({vecs[i].name, "_fwd"},   70'(ms_result), 70'(vecs[i].result));
            checkOutput({vecs[i].name, "_valid"}, 70'(ms_to_ws_valid), 70'd1);
            checkOutput({vecs[i].name, "_dest"},  70'(ms_dest), 70'd8);
            @(posedge clk);
            #1 data_data_ok = 1'b0;
            @(negedge clk);
            checkOutput({vecs[i].name, "_empty"}, 70'(ms_to_ws_valid), 70'd0);
            @(posedge clk);
            #1;
        end

        // Write-back stalled while the data arrives: it must be held, not re-sampled.
        ws_allowin = 1'b0;
        applyStimulus(make_bus(1'b0, 32'h0, 1'b0, 32'h0, 12'h010, 1'b1, 1'b1, 5'd5,
                               32'h80004000, 32'hBFC01000),
                      {1'b1, 5'd5, 32'hDEADBEEF, 32'hBFC01000});
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("buf_first_allowin", 70'(ms_allowin), 70'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            data_data_ok = (k == 1);
            data_rdata   = (k == 1) ? 32'h55555555 : 32'h0BADF00D;
            @(negedge clk);
            checkOutput("buf_allowin", 70'(ms_allowin), 70'd0);
            checkOutput("buf_valid",   70'(ms_to_ws_valid), 70'd1);
            checkOutput("buf_result",  70'(ms_result), 70'(32'hDEADBEEF));
            @(posedge clk);
            #1;
        end
        data_data_ok = 1'b0;
        ws_allowin   = 1'b1;
        @(negedge clk);
        checkOutput("buf_release", 70'(ms_result), 70'(32'hDEADBEEF));
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("buf_empty", 70'(ms_to_ws_valid), 70'd0);
        @(posedge clk);
        #1;

        applyStimulus(make_bus(1'b0, 32'h0, 1'b1, 32'h0, 12'h010, 1'b1, 1'b1, 5'd7,
                               32'h00001234, 32'hBFC02000),
                      {1'b0, 5'd7, 32'h00001234, 32'hBFC02000});
        @(negedge clk);
        checkOutput("ex_valid",    70'(ms_to_ws_valid), 70'd1);
        checkOutput("ex_dest",     70'(ms_dest), 70'd0);
        checkOutput("ex_loadwait", 70'(ms_load_wait), 70'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("ex_empty", 70'(ms_to_ws_valid), 70'd0);
        @(posedge clk);
        #1;

        cnt = 0;
        applyStimulus(make_bus(1'b0, 32'h0, 1'b0, 32'h0, 12'h010, 1'b1, 1'b1, 5'd9,
                               32'h80005000, 32'hBFC03000),
                      {1'b1, 5'd9, 32'hCAFEF00D, 32'hBFC03000});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ms_load_wait) cnt++;
            @(posedge clk);
            #1;
        end
        data_data_ok = 1'b1;
        data_rdata   = 32'hCAFEF00D;
        @(negedge clk);
        if (ms_load_wait) cnt++;
        checkOutput("wait_fwd",  70'(ms_result), 70'(32'hCAFEF00D));
        checkOutput("wait_dest", 70'(ms_dest), 70'd9);
        @(posedge clk);
        #1 data_data_ok = 1'b0;
        @(negedge clk);
        if (ms_load_wait) cnt++;
        checkOutput("load_wait_cycles", 70'(cnt), 70'd4);
        @(posedge clk);
        #1;

        applyStimulus(make_bus(1'b1, 32'h0000ABCD, 1'b0, 32'h0, 12'h000, 1'b0, 1'b1, 5'd3,
                               32'h11111111, 32'hBFC04000),
                      {1'b1, 5'd3, 32'h0000ABCD, 32'hBFC04000});
        @(negedge clk);
        checkOutput("mfc0_fwd",  70'(ms_result), 70'(32'h0000ABCD));
        checkOutput("mfc0_dest", 70'(ms_dest), 70'd3);
        @(posedge clk);
        #1;

        applyStimulus(make_bus(1'b0, 32'h0, 1'b0, 32'h0, 12'h010, 1'b1, 1'b1, 5'd6,
                               32'h80006000, 32'hBFC05000),
                      {1'b1, 5'd6, 32'h0, 32'hBFC05000});
        @(negedge clk);
        checkOutput("rst_pre_wait", 70'(ms_load_wait), 70'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checkIdle("rstwait");
        @(posedge clk);
        #1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h77777777;
        @(negedge clk);
        checkOutput("late_ok_valid", 70'(ms_to_ws_valid), 70'd0);
        @(posedge clk);
        #1 data_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("late_ok_after", 70'(ms_to_ws_valid), 70'd0);
        checkOutput("late_ok_allowin", 70'(ms_allowin), 70'd1);
        @(posedge clk);
        #1;

        // Second load is captured on the same edge the first one leaves.
        applyStimulus(make_bus(1'b0, 32'h0, 1'b0, 32'h0, 12'h010, 1'b1, 1'b1, 5'd4,
                               32'h80003000, 32'hBFC06000),
                      {1'b1, 5'd4, 32'hA0A0A0A0, 32'hBFC06000});
        data_data_ok = 1'b1;
        data_rdata   = 32'hA0A0A0A0;
        applyStimulus(make_bus(1'b0, 32'h0, 1'b0, 32'h0, 12'h002, 1'b1, 1'b1, 5'd2,
                               32'h80003001, 32'hBFC06004),
                      {1'b1, 5'd2, 32'h000000C3, 32'hBFC06004});
        data_rdata = 32'h0000C300;
        @(negedge clk);
        checkOutput("b2b_valid", 70'(ms_to_ws_valid), 70'd1);
        checkOutput("b2b_fwd",   70'(ms_result), 70'(32'h000000C3));
        @(posedge clk);
        #1 data_data_ok = 1'b0;
        @(negedge clk);
        checkOutput("b2b_empty", 70'(ms_to_ws_valid), 70'd0);

        checkOutput("sb_drained", 70'(sb.size()), 70'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
